// File: rtl/cmplx_ram_pkg.sv
// Shared types, default sizes and helpers for the complex dual-port sample memory.
// Used by cmplx_ram_dp_ctl (FSM/loader) and its interface.
package cmplx_ram_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2
  } state_t;

  // Reverse the low w bits of v. Bits at and above w come back as zero.
  // This supports address widths of up to 32 bits.
  function automatic logic [31:0] bit_reverse(input logic [31:0] v, input int w);
    logic [31:0] r;
    logic [31:0] vv;
    r  = '0;
    vv = v;
    for (int i = 0; i < 32; i++) begin
      if (i < w) begin
        r  = {r[30:0], vv[0]};
        vv = vv >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/cmplx_ram_dp_ctl_if.sv
// Bus bundle for cmplx_ram_dp_ctl. It groups the mode pulses, the sample
// stream, the two butterfly access ports and the status flags.
// The master side is the front end / sequencer. The slave side is the memory controller.
interface cmplx_ram_dp_ctl_if
  import cmplx_ram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);
  logic              start_load;
  logic              compute_done;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_real;
  logic [DATA_W-1:0] s_imag;
  logic              load_done;
  logic              busy_load;
  logic              acc_en;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] dreal_a;
  logic [DATA_W-1:0] dimg_a;
  logic [DATA_W-1:0] dreal_b;
  logic [DATA_W-1:0] dimg_b;
  logic              wren_a;
  logic              wren_b;
  logic [DATA_W-1:0] qreal_a;
  logic [DATA_W-1:0] qimg_a;
  logic [DATA_W-1:0] qreal_b;
  logic [DATA_W-1:0] qimg_b;
  logic              q_valid;
  logic              collision;

  modport master (
    output start_load, compute_done, s_valid, s_real, s_imag,
           acc_en, addr_a, addr_b, dreal_a, dimg_a, dreal_b, dimg_b, wren_a, wren_b,
    input  s_ready, load_done, busy_load, qreal_a, qimg_a, qreal_b, qimg_b, q_valid, collision
  );

  modport slave (
    input  start_load, compute_done, s_valid, s_real, s_imag,
           acc_en, addr_a, addr_b, dreal_a, dimg_a, dreal_b, dimg_b, wren_a, wren_b,
    output s_ready, load_done, busy_load, qreal_a, qimg_a, qreal_b, qimg_b, q_valid, collision
  );
endinterface

// File: rtl/cmplx_dpram_core.sv
// Inferred true-dual-port complex array. The real and imaginary planes share
// the same addresses. When both ports write one address, port A wins. A read
// always returns the contents from before the edge, including during a write.
module cmplx_dpram_core #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] d_re_a,
  input  logic [DATA_W-1:0] d_im_a,
  output logic [DATA_W-1:0] q_re_a,
  output logic [DATA_W-1:0] q_im_a,
  input  logic              rd_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] d_re_b,
  input  logic [DATA_W-1:0] d_im_b,
  output logic [DATA_W-1:0] q_re_b,
  output logic [DATA_W-1:0] q_im_b
);

  logic [DATA_W-1:0] mem_re [2**ADDR_W];
  logic [DATA_W-1:0] mem_im [2**ADDR_W];

  logic b_blocked;
  assign b_blocked = we_a && (addr_a == addr_b);

  // Array writes. Port B yields to port A on an address clash.
  // NOTE: the storage array has no reset branch. A reset would prevent RAM inference and cannot clear N words in one cycle anyway.
  always_ff @(posedge clk) begin
    if (we_a) begin
      mem_re[addr_a] <= d_re_a;
      mem_im[addr_a] <= d_im_a;
    end
    if (we_b && !b_blocked) begin
      mem_re[addr_b] <= d_re_b;
      mem_im[addr_b] <= d_im_b;
    end
  end

  // Registered reads. The output holds its value when the port is not reading.
  // NOTE: non-blocking writes above mean these reads see pre-edge contents, which gives old-data read-during-write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_re_a <= '0;
      q_im_a <= '0;
      q_re_b <= '0;
      q_im_b <= '0;
    end else begin
      if (rd_a) begin
        q_re_a <= mem_re[addr_a];
        q_im_a <= mem_im[addr_a];
      end
      if (rd_b) begin
        q_re_b <= mem_re[addr_b];
        q_im_b <= mem_im[addr_b];
      end
    end
  end

endmodule

// File: rtl/cmplx_ram_dp_ctl.sv
// Complex sample memory controller for the FFT datapath.
// IDLE: readout only. LOAD: streams N samples in. COMPUTE: both ports serve the butterfly.
// Optional macro CMPLX_RAM_BITREV_EN: when defined, LOAD stores sample c at
// bit_reverse(c). This allows in-place DIT processing.
module cmplx_ram_dp_ctl
  import cmplx_ram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  cmplx_ram_dp_ctl_if.slave  bus
);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] wr_addr;
  logic              accept;
  logic              last;

  logic              rd_a, rd_b, we_a, we_b;
  logic [ADDR_W-1:0] core_addr_a;
  logic [DATA_W-1:0] core_re_a, core_im_a;

  assign accept = bus.s_valid && (state == LOAD);
  assign last   = accept && (&cnt);

`ifdef CMPLX_RAM_BITREV_EN
  logic [31:0] cnt_rev;
  assign cnt_rev = bit_reverse(32'(cnt), ADDR_W);
  assign wr_addr = cnt_rev[ADDR_W-1:0];
`else
  assign wr_addr = cnt;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic. Mode pulses are ignored outside their own state.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start_load)   state_nxt = LOAD;
      LOAD:    if (last)             state_nxt = COMPUTE;
      COMPUTE: if (bus.compute_done) state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  // Output/steering logic. The loader takes port A in LOAD; otherwise the external bus drives both ports.
  // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    bus.s_ready   = 1'b0;
    bus.busy_load = 1'b0;
    rd_a          = 1'b0;
    rd_b          = 1'b0;
    we_a          = 1'b0;
    we_b          = 1'b0;
    core_addr_a   = bus.addr_a;
    core_re_a     = bus.dreal_a;
    core_im_a     = bus.dimg_a;
    unique case (state)
      LOAD: begin
        bus.s_ready   = 1'b1;
        bus.busy_load = 1'b1;
        we_a          = bus.s_valid;
        core_addr_a   = wr_addr;
        core_re_a     = bus.s_real;
        core_im_a     = bus.s_imag;
      end
      COMPUTE: begin
        rd_a = bus.acc_en;
        rd_b = bus.acc_en;
        we_a = bus.acc_en && bus.wren_a;
        we_b = bus.acc_en && bus.wren_b;
      end
      IDLE: begin
        rd_a = bus.acc_en;
        rd_b = bus.acc_en;
      end
      default: ;
    endcase
  end

  // Load counter, load_done pulse, read-valid and sticky collision flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt           <= '0;
      bus.load_done <= 1'b0;
      bus.q_valid   <= 1'b0;
      bus.collision <= 1'b0;
    end else begin
      if (accept) cnt <= cnt + 1'b1;
      bus.load_done <= last;
      bus.q_valid   <= bus.acc_en && (state != LOAD);
      if (we_a && we_b && (core_addr_a == bus.addr_b)) bus.collision <= 1'b1;
    end
  end

  cmplx_dpram_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .rd_a   (rd_a),
    .we_a   (we_a),
    .addr_a (core_addr_a),
    .d_re_a (core_re_a),
    .d_im_a (core_im_a),
    .q_re_a (bus.qreal_a),
    .q_im_a (bus.qimg_a),
    .rd_b   (rd_b),
    .we_b   (we_b),
    .addr_b (bus.addr_b),
    .d_re_b (bus.dreal_b),
    .d_im_b (bus.dimg_b),
    .q_re_b (bus.qreal_b),
    .q_im_b (bus.qimg_b)
  );

endmodule

// File: tb/tb_cmplx_ram_dp_ctl.sv
// Self-checking bench for cmplx_ram_dp_ctl with ADDR_W=3 (N=8).
// An array-based reference model predicts every output after each edge.
// Directed sequences and a table of readbacks cover the corner cases.
module tb_cmplx_ram_dp_ctl;
  localparam int DW = 32;
  localparam int AW = 3;
  localparam int N  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cmplx_ram_dp_ctl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  cmplx_ram_dp_ctl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_LOAD, M_COMPUTE} mode_e;
  mode_e          m_mode;
  int             m_cnt;
  logic [DW-1:0]  m_re [N];
  logic [DW-1:0]  m_im [N];
  bit             m_known [N];
  logic [DW-1:0]  e_qra, e_qia, e_qrb, e_qib;
  bit             e_qa_known, e_qb_known;
  bit             e_qv, e_col, e_ld;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic [AW-1:0] addr_a;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] re_a, im_a, re_b, im_b;
  } vec_t;
  vec_t tbl [3];

  int            accepts;
  bit            got_done;
  logic [DW-1:0] old_re, old_im;

  // Storage position of the c-th loaded sample
  function automatic int place(int c);
`ifdef CMPLX_RAM_BITREV_EN
    int r = 0;
    for (int i = 0; i < AW; i++) r = r * 2 + ((c >> i) & 1);
    return r;
`else
    return c;
`endif
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs that are currently applied
  task automatic model_edge();
    int a, b, pa;
    e_ld = 1'b0;
    if (!rst_n) begin
      m_mode = M_IDLE; m_cnt = 0; e_qv = 1'b0; e_col = 1'b0;
      e_qra = '0; e_qia = '0; e_qrb = '0; e_qib = '0;
      e_qa_known = 1'b1; e_qb_known = 1'b1;
      return;
    end
    if (m_mode == M_LOAD) begin
      e_qv = 1'b0;
      if (bus.s_valid) begin
        pa = place(m_cnt);
        m_re[pa] = bus.s_real; m_im[pa] = bus.s_imag; m_known[pa] = 1'b1;
        m_cnt++;
        if (m_cnt == N) begin
          m_cnt = 0; m_mode = M_COMPUTE; e_ld = 1'b1;
        end
      end
    end else begin
      e_qv = bus.acc_en;
      if (bus.acc_en) begin
        a = int'(bus.addr_a);
        b = int'(bus.addr_b);
        e_qra = m_re[a]; e_qia = m_im[a]; e_qa_known = m_known[a];
        e_qrb = m_re[b]; e_qib = m_im[b]; e_qb_known = m_known[b];
        if (m_mode == M_COMPUTE) begin
          if (bus.wren_b && !(bus.wren_a && a == b)) begin
            m_re[b] = bus.dreal_b; m_im[b] = bus.dimg_b; m_known[b] = 1'b1;
          end
          if (bus.wren_a) begin
            m_re[a] = bus.dreal_a; m_im[a] = bus.dimg_a; m_known[a] = 1'b1;
          end
          if (bus.wren_a && bus.wren_b && a == b) e_col = 1'b1;
        end
      end
      if (m_mode == M_IDLE && bus.start_load) m_mode = M_LOAD;
      else if (m_mode == M_COMPUTE && bus.compute_done) m_mode = M_IDLE;
    end
  endtask

  // One clock: predict, step, then compare every output away from the edge
  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    check("s_ready",   32'(bus.s_ready),   32'(m_mode == M_LOAD));
    check("busy_load", 32'(bus.busy_load), 32'(m_mode == M_LOAD));
    check("load_done", 32'(bus.load_done), 32'(e_ld));
    check("q_valid",   32'(bus.q_valid),   32'(e_qv));
    check("collision", 32'(bus.collision), 32'(e_col));
    if (e_qa_known) begin
      check("qreal_a", bus.qreal_a, e_qra);
      check("qimg_a",  bus.qimg_a,  e_qia);
    end
    if (e_qb_known) begin
      check("qreal_b", bus.qreal_b, e_qrb);
      check("qimg_b",  bus.qimg_b,  e_qib);
    end
  endtask

  task automatic clr();
    bus.start_load = 1'b0; bus.compute_done = 1'b0;
    bus.s_valid = 1'b0; bus.s_real = '0; bus.s_imag = '0;
    bus.acc_en = 1'b0; bus.addr_a = '0; bus.addr_b = '0;
    bus.dreal_a = '0; bus.dimg_a = '0; bus.dreal_b = '0; bus.dimg_b = '0;
    bus.wren_a = 1'b0; bus.wren_b = 1'b0;
  endtask

  task automatic rand_inputs(int p_start, int p_done);
    bus.start_load   = ($urandom_range(0, p_start - 1) == 0);
    bus.compute_done = ($urandom_range(0, p_done - 1) == 0);
    bus.s_valid = 1'($urandom_range(0, 1));
    bus.s_real  = $urandom; bus.s_imag = $urandom;
    bus.acc_en  = 1'($urandom_range(0, 1));
    bus.addr_a  = AW'($urandom_range(0, N - 1));
    bus.addr_b  = AW'($urandom_range(0, N - 1));
    bus.dreal_a = $urandom; bus.dimg_a = $urandom;
    bus.dreal_b = $urandom; bus.dimg_b = $urandom;
    bus.wren_a  = ($urandom_range(0, 2) == 0);
    bus.wren_b  = ($urandom_range(0, 2) == 0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) m_known[i] = 1'b0;
    // Readback table after loading sample i as (i, -i)
`ifdef CMPLX_RAM_BITREV_EN
    tbl[0] = '{addr_a: 3'd4, addr_b: 3'd6, re_a: 32'd1, im_a: -32'd1, re_b: 32'd3, im_b: -32'd3};
    tbl[1] = '{addr_a: 3'd5, addr_b: 3'd1, re_a: 32'd5, im_a: -32'd5, re_b: 32'd4, im_b: -32'd4};
    tbl[2] = '{addr_a: 3'd3, addr_b: 3'd0, re_a: 32'd6, im_a: -32'd6, re_b: 32'd0, im_b: 32'd0};
`else
    tbl[0] = '{addr_a: 3'd5, addr_b: 3'd0, re_a: 32'd5, im_a: -32'd5, re_b: 32'd0, im_b: 32'd0};
    tbl[1] = '{addr_a: 3'd3, addr_b: 3'd7, re_a: 32'd3, im_a: -32'd3, re_b: 32'd7, im_b: -32'd7};
    tbl[2] = '{addr_a: 3'd1, addr_b: 3'd6, re_a: 32'd1, im_a: -32'd1, re_b: 32'd6, im_b: -32'd6};
`endif

    clr();
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;

    // Load 8 samples (i, -i) back to back
    bus.start_load = 1'b1; cycle(); bus.start_load = 1'b0;
    for (int i = 0; i < N; i++) begin
      bus.s_valid = 1'b1; bus.s_real = 32'(i); bus.s_imag = -32'(i);
      cycle();
      if (i == N - 1) check("load_done_after_8th", 32'(bus.load_done), 32'd1);
    end
    bus.s_valid = 1'b0;
    bus.compute_done = 1'b1; cycle(); bus.compute_done = 1'b0;

    // IDLE readback table
    for (int k = 0; k < 3; k++) begin
      bus.acc_en = 1'b1; bus.addr_a = tbl[k].addr_a; bus.addr_b = tbl[k].addr_b;
      cycle();
      bus.acc_en = 1'b0;
      check("tbl_qv",      32'(bus.q_valid), 32'd1);
      check("tbl_qreal_a", bus.qreal_a, tbl[k].re_a);
      check("tbl_qimg_a",  bus.qimg_a,  tbl[k].im_a);
      check("tbl_qreal_b", bus.qreal_b, tbl[k].re_b);
      check("tbl_qimg_b",  bus.qimg_b,  tbl[k].im_b);
      cycle();
    end

    // Backpressure load with random gaps
    bus.start_load = 1'b1; cycle(); bus.start_load = 1'b0;
    accepts = 0; got_done = 1'b0;
    for (int c = 0; c < 200 && !got_done; c++) begin
      bus.s_valid = 1'($urandom_range(0, 1));
      bus.s_real = $urandom; bus.s_imag = $urandom;
      if (bus.s_valid) accepts++;
      cycle();
      if (bus.load_done) begin
        got_done = 1'b1;
        check("bp_accepts", 32'(accepts), 32'd8);
      end
    end
    bus.s_valid = 1'b0;
    check("bp_done_seen", 32'(got_done), 32'd1);

    // COMPUTE: dual write to the same address, A wins
    bus.acc_en = 1'b1; bus.addr_a = 3'd2; bus.addr_b = 3'd2;
    bus.wren_a = 1'b1; bus.wren_b = 1'b1;
    bus.dreal_a = 32'hA; bus.dimg_a = 32'hA; bus.dreal_b = 32'hB; bus.dimg_b = 32'hB;
    cycle();
    bus.wren_a = 1'b0; bus.wren_b = 1'b0;
    cycle();
    check("dw_qreal_a", bus.qreal_a, 32'hA);
    check("dw_qimg_a",  bus.qimg_a,  32'hA);
    check("dw_qreal_b", bus.qreal_b, 32'hA);
    check("dw_coll",    32'(bus.collision), 32'd1);
    bus.acc_en = 1'b0;
    cycle(); cycle();
    check("dw_coll_sticky", 32'(bus.collision), 32'd1);

    // Read-during-write: A writes (7,7) to addr 1 while B reads addr 1
    old_re = m_re[1]; old_im = m_im[1];
    bus.acc_en = 1'b1; bus.addr_a = 3'd1; bus.addr_b = 3'd1;
    bus.wren_a = 1'b1; bus.dreal_a = 32'd7; bus.dimg_a = 32'd7;
    cycle();
    check("rdw_old_re", bus.qreal_b, old_re);
    check("rdw_old_im", bus.qimg_b,  old_im);
    bus.wren_a = 1'b0;
    cycle();
    check("rdw_new_re", bus.qreal_b, 32'd7);
    check("rdw_new_im", bus.qimg_b,  32'd7);

    // Random COMPUTE traffic, with stray start_load pulses that must be ignored
    for (int c = 0; c < 150; c++) begin
      rand_inputs(6, 1000000);
      bus.compute_done = 1'b0;
      cycle();
    end
    clr();
    bus.compute_done = 1'b1; cycle(); bus.compute_done = 1'b0;

    // Reset mid-LOAD after 3 samples, then reload from counter 0
    bus.start_load = 1'b1; cycle(); bus.start_load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.s_valid = 1'b1; bus.s_real = 32'(100 + i); bus.s_imag = 32'(150 + i);
      cycle();
    end
    bus.s_valid = 1'b0;
    rst_n = 1'b0; cycle(); rst_n = 1'b1;
    check("rst_s_ready", 32'(bus.s_ready), 32'd0);
    check("rst_coll",    32'(bus.collision), 32'd0);
    bus.start_load = 1'b1; cycle(); bus.start_load = 1'b0;
    for (int i = 0; i < N; i++) begin
      bus.s_valid = 1'b1; bus.s_real = 32'(200 + i); bus.s_imag = 32'(300 + i);
      cycle();
      if (i == N - 1) check("reload_done", 32'(bus.load_done), 32'd1);
    end
    bus.s_valid = 1'b0;
    bus.compute_done = 1'b1; cycle(); bus.compute_done = 1'b0;
    bus.acc_en = 1'b1; bus.addr_a = AW'(place(0)); bus.addr_b = AW'(place(1));
    cycle();
    bus.acc_en = 1'b0;
    check("reload_s0_re", bus.qreal_a, 32'd200);
    check("reload_s0_im", bus.qimg_a,  32'd300);
    check("reload_s1_re", bus.qreal_b, 32'd201);

    // Fully random traffic across all modes
    for (int c = 0; c < 400; c++) begin
      rand_inputs(8, 16);
      cycle();
    end
    clr();
    cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
